counter_mod: RTL and testbench

COUNTER_MOD -- requirements
Module: counter_mod

---
 rtl/counter_mod_pkg.sv | 18 +
 rtl/counter_mod_prescaler.sv | 36 +++
 rtl/counter_mod.sv | 127 ++++++++++++
 tb/tb_counter_mod.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_mod_pkg.sv
// Shared defaults and helpers for the modulo up/down counter.
// Pure declarations; no logic, no latency, no backpressure.
package counter_mod_pkg;

    localparam int     DEF_WIDTH    = 8;
    localparam longint DEF_MODULUS  = 256;
    localparam int     DEF_PRESCALE = 1;
    localparam int     DEF_SATURATE = 0;

    // ceil(log2(p)), never narrower than one bit so PRESCALE=1 still has a register
    function automatic int presc_width(input int p);
        if (p <= 2) begin
            return 1;
        end
        return $clog2(p);
    endfunction

endpackage

// File: rtl/counter_mod_prescaler.sv
// Divides enabled clocks by PRESCALE; tick marks the last enabled clock of a phase.
// Latency: tick is combinational from enable and the phase register; phase holds while enable is low.
module prescaler
    import counter_mod_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic clr_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + PW'(1);
            end
        end
    end

endmodule

// File: rtl/counter_mod.sv
// Modulo-MODULUS up/down counter with load clamp, prescaler, wrap or saturate at the limits.
// Latency: c, tc and sat update together on the stepping edge; s_s=0 holds everything (no other backpressure).
module counter_mod
    import counter_mod_pkg::*;
#(
    parameter int     WIDTH    = DEF_WIDTH,
    parameter longint MODULUS  = DEF_MODULUS,
    parameter int     PRESCALE = DEF_PRESCALE,
    parameter int     SATURATE = DEF_SATURATE
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             clr,
    input  logic             l,
    input  logic             s_s,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] c,
    output logic             tc,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic             run_q;
    logic             pre_en;
    logic             tick;
    logic             at_max;
    logic             at_zero;
    logic             dir_at_limit;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] c_step;
    logic             tc_step;
    logic             sat_step;

    // Reset release is captured here first; the count register is the second
    // stage, so the earliest step lands on the second edge after clr_n rises.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign pre_en = s_s && run_q && !clr && !l;

    prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .clr_n  (clr_n),
        .clear  (clr || l),
        .enable (pre_en),
        .tick   (tick)
    );

    assign at_max       = (c == MAX_C);
    assign at_zero      = (c == '0);
    assign dir_at_limit = up ? at_max : at_zero;
    assign load_val     = (d > MAX_C) ? MAX_C : d;

    always_comb begin
        c_step   = c;
        tc_step  = 1'b0;
        sat_step = 1'b0;
        if (up) begin
            if (at_max) begin
                if (SATURATE != 0) begin
                    sat_step = 1'b1;
                end else begin
                    c_step  = '0;
                    tc_step = 1'b1;
                end
            end else begin
                c_step = c + ONE;
                if ((SATURATE != 0) && (c_step == MAX_C)) begin
                    tc_step  = 1'b1;
                    sat_step = 1'b1;
                end
            end
        end else begin
            if (at_zero) begin
                if (SATURATE != 0) begin
                    sat_step = 1'b1;
                end else begin
                    c_step  = MAX_C;
                    tc_step = 1'b1;
                end
            end else begin
                c_step = c - ONE;
                if ((SATURATE != 0) && (c_step == '0)) begin
                    tc_step  = 1'b1;
                    sat_step = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            c   <= '0;
            tc  <= 1'b0;
            sat <= 1'b0;
        end else if (clr) begin
            c   <= '0;
            tc  <= 1'b0;
            sat <= 1'b0;
        end else if (l) begin
            c   <= load_val;
            tc  <= 1'b0;
            sat <= 1'b0;
        end else if (!s_s || !run_q) begin
            tc <= 1'b0;
        end else if (tick) begin
            c   <= c_step;
            tc  <= tc_step;
            sat <= sat_step;
        end else begin
            // between prescaled steps a direction flip away from the limit drops sat
            tc  <= 1'b0;
            sat <= sat && dir_at_limit;
        end
    end

endmodule

// File: tb/tb_counter_mod.sv
module tb_counter_mod;

    localparam int D_DEF = 0;
    localparam int D_M10 = 1;
    localparam int D_SAT = 2;
    localparam int D_P4  = 3;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       clr;
    logic       l;
    logic       s_s;
    logic       up;
    logic [7:0] d;

    logic [7:0] c_def, c_m10, c_sat, c_p4;
    logic       tc_def, tc_m10, tc_sat, tc_p4;
    logic       sat_def, sat_m10, sat_sat, sat_p4;

    always #5 clk = ~clk;

    counter_mod u_def (
        .clk(clk), .clr_n(clr_n), .clr(clr), .l(l), .s_s(s_s), .up(up), .d(d),
        .c(c_def), .tc(tc_def), .sat(sat_def)
    );

    counter_mod #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) u_m10 (
        .clk(clk), .clr_n(clr_n), .clr(clr), .l(l), .s_s(s_s), .up(up), .d(d),
        .c(c_m10), .tc(tc_m10), .sat(sat_m10)
    );

    counter_mod #(.WIDTH(8), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clk(clk), .clr_n(clr_n), .clr(clr), .l(l), .s_s(s_s), .up(up), .d(d),
        .c(c_sat), .tc(tc_sat), .sat(sat_sat)
    );

    counter_mod #(.WIDTH(8), .MODULUS(256), .PRESCALE(4), .SATURATE(0)) u_p4 (
        .clk(clk), .clr_n(clr_n), .clr(clr), .l(l), .s_s(s_s), .up(up), .d(d),
        .c(c_p4), .tc(tc_p4), .sat(sat_p4)
    );

    typedef struct {
        string      tag;
        int         dut;
        logic [7:0] c;
        logic       tc;
        logic       sat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic void obs(input int dut, output logic [7:0] oc, output logic otc,
                                output logic osat);
        case (dut)
            D_M10:   begin oc = c_m10; otc = tc_m10; osat = sat_m10; end
            D_SAT:   begin oc = c_sat; otc = tc_sat; osat = sat_sat; end
            D_P4:    begin oc = c_p4;  otc = tc_p4;  osat = sat_p4;  end
            default: begin oc = c_def; otc = tc_def; osat = sat_def; end
        endcase
    endfunction

    task automatic check_now(input string tag, input int dut, input logic [7:0] ec,
                             input logic etc, input logic esat);
        logic [7:0] oc;
        logic       otc, osat;
        obs(dut, oc, otc, osat);
        chk_eq({tag, "_c"},   32'(oc),   32'(ec));
        chk_eq({tag, "_tc"},  32'(otc),  32'(etc));
        chk_eq({tag, "_sat"}, 32'(osat), 32'(esat));
    endtask

    task automatic expect_out(input string tag, input int dut, input logic [7:0] ec,
                              input logic etc, input logic esat);
        exp_t e;
        e.tag = tag;
        e.dut = dut;
        e.c   = ec;
        e.tc  = etc;
        e.sat = esat;
        sb.push_back(e);
    endtask

    // one rising edge, then score everything queued for it
    task automatic cycle();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_now(e.tag, e.dut, e.c, e.tc, e.sat);
        end
    endtask

    task automatic do_clear(input int dut);
        clr = 1'b1; l = 1'b0; s_s = 1'b0;
        expect_out("clr", dut, 8'h00, 1'b0, 1'b0);
        cycle();
        clr = 1'b0;
    endtask

    initial begin
        logic [7:0] dn_seq [5];
        logic [7:0] p4_seq [6];
        logic [7:0] p4_res [6];
        dn_seq = '{8'd2, 8'd1, 8'd0, 8'd9, 8'd8};
        p4_seq = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
        p4_res = '{8'd1, 8'd2, 8'd2, 8'd2, 8'd2, 8'd3};

        clr_n = 1'b0; clr = 1'b0; l = 1'b0; s_s = 1'b0; up = 1'b0; d = 8'h00;

        #50;
        for (int i = 0; i < 4; i++) begin
            check_now($sformatf("rst%0d", i), i, 8'h00, 1'b0, 1'b0);
        end
        s_s = 1'b1; up = 1'b1;
        #50;
        clr_n = 1'b1;

        // full up-count wrap on the default build
        for (int k = 1; k <= 260; k++) begin
            expect_out($sformatf("run%0d", k), D_DEF, 8'((k - 1) % 256), (k == 257), 1'b0);
            cycle();
        end

        // async reset between edges while holding a loaded value
        s_s = 1'b0; l = 1'b1; d = 8'h55;
        expect_out("ld55", D_DEF, 8'h55, 1'b0, 1'b0);
        cycle();
        l = 1'b0;
        #3;
        clr_n = 1'b0;
        #1;
        check_now("async", D_DEF, 8'h00, 1'b0, 1'b0);
        #1;
        clr_n = 1'b1;
        s_s = 1'b1; up = 1'b1;
        expect_out("rel_e1", D_DEF, 8'h00, 1'b0, 1'b0);
        cycle();
        expect_out("rel_e2", D_DEF, 8'h01, 1'b0, 1'b0);
        cycle();

        // clear beats load; load beats step
        clr = 1'b1; l = 1'b1; d = 8'h77; s_s = 1'b1;
        expect_out("clr_ld", D_DEF, 8'h00, 1'b0, 1'b0);
        cycle();
        clr = 1'b0; d = 8'h20;
        expect_out("ld_run", D_DEF, 8'h20, 1'b0, 1'b0);
        cycle();
        l = 1'b0;
        expect_out("post_ld", D_DEF, 8'h21, 1'b0, 1'b0);
        cycle();

        // modulus-10 down count with wrap
        do_clear(D_M10);
        up = 1'b0; l = 1'b1; d = 8'h03;
        expect_out("m10_ld", D_M10, 8'h03, 1'b0, 1'b0);
        cycle();
        l = 1'b0; s_s = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("m10_dn%0d", i), D_M10, dn_seq[i], (dn_seq[i] == 8'd9), 1'b0);
            cycle();
        end
        s_s = 1'b0; l = 1'b1; d = 8'hF0;
        expect_out("m10_clamp", D_M10, 8'h09, 1'b0, 1'b0);
        cycle();
        l = 1'b0;

        // saturating limits
        do_clear(D_SAT);
        up = 1'b1; l = 1'b1; d = 8'hF0;
        expect_out("sat_ld", D_SAT, 8'h09, 1'b0, 1'b0);
        cycle();
        l = 1'b0; s_s = 1'b1;
        expect_out("sat_hi", D_SAT, 8'h09, 1'b0, 1'b1);
        cycle();
        up = 1'b0;
        expect_out("sat_off", D_SAT, 8'h08, 1'b0, 1'b0);
        cycle();
        for (int i = 7; i >= 1; i--) begin
            expect_out($sformatf("sat_dn%0d", i), D_SAT, 8'(i), 1'b0, 1'b0);
            cycle();
        end
        expect_out("sat_lo_hit", D_SAT, 8'h00, 1'b1, 1'b1);
        cycle();
        expect_out("sat_lo_hold", D_SAT, 8'h00, 1'b0, 1'b1);
        cycle();
        s_s = 1'b0;
        expect_out("sat_stop", D_SAT, 8'h00, 1'b0, 1'b1);
        cycle();
        s_s = 1'b1; up = 1'b1;
        expect_out("sat_leave", D_SAT, 8'h01, 1'b0, 1'b0);
        cycle();

        // prescale by 4, with a pause in the middle of a phase
        do_clear(D_P4);
        s_s = 1'b1; up = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_out($sformatf("p4_a%0d", i), D_P4, p4_seq[i], 1'b0, 1'b0);
            cycle();
        end
        s_s = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_out($sformatf("p4_hold%0d", i), D_P4, 8'h01, 1'b0, 1'b0);
            cycle();
        end
        s_s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_out($sformatf("p4_b%0d", i), D_P4, p4_res[i], 1'b0, 1'b0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
